step_counter: RTL and testbench
===============================

# step_counter

Parametrised loadable up/down step counter with a run/done sequencer. It generalises the divider's single-step decrementer. The counter is loaded with a start value and a direction, then moves by a programmable stride on each enabled cycle until it reaches its terminal value (zero when counting down, `limit` when counting up). Crossing the terminal value either saturates or wraps. The divider and multiplier control units use it as their iteration counter and read `done` as the loop-exit strobe.

## Interface
- `WIDTH`, 4: width of the count, the start value, the stride and the limit.
- `SATURATE`, 0: 1 clamps at the terminal value on overshoot; 0 wraps modulo 2^WIDTH.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_b` in 1: synchronous, active-high reset.
- `start` in 1: load `init`, latch `dir` and `limit`, begin a run.
- `init` in WIDTH: start value.
- `dir` in 1: 1 = count up toward `limit`; 0 = count down toward 0. Sampled only on `start`.
- `limit` in WIDTH: up-mode terminal value. Sampled only on `start`.
- `step` in WIDTH: stride. Sampled every enabled cycle.
- `enable` in 1: advance the count this cycle when in RUN.
- `count` out WIDTH: current count, registered.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse while in DONE.
- `wrap` out 1: sticky; set on a wrapping overshoot, cleared by `start`.

## Operation
- FSM states: IDLE, RUN, DONE. The outputs `busy` and `done` decode directly from the state register.
- The target is 0 when the latched direction is down, and the latched `limit` when it is up.
- **Reset** (`rst_b`=1 at an edge) takes priority over everything and sets:
  - state = IDLE, `count` = 0, `busy` = 0, `done` = 0, `wrap` = 0;
  - latched `dir` = 0, latched `limit` = 0.
- **Start** is accepted in any state and has priority over `enable`. On `start`:
  - `count` ← `init`, and `dir`/`limit` are latched;
  - `wrap` ← 0;
  - if `init` equals the target, next state is DONE; otherwise it is RUN.
- **Advance** happens in RUN with `enable`=1 and `start`=0. The arithmetic uses a WIDTH+1-bit sum or difference.
- Down direction:
  - If `step` < `count`: `count` ← `count` − `step`, stay in RUN.
  - If `step` == `count`: `count` ← 0, go to DONE.
  - If `step` > `count` and SATURATE=1: `count` ← 0, go to DONE.
  - If `step` > `count` and SATURATE=0: `count` ← (`count` − `step`) mod 2^WIDTH, `wrap` ← 1, go to DONE.
- Up direction:
  - If `count` + `step` < `limit`: `count` ← `count` + `step`, stay in RUN.
  - If `count` + `step` == `limit`: `count` ← `limit`, go to DONE.
  - If `count` + `step` > `limit` and SATURATE=1: `count` ← `limit`, go to DONE.
  - If `count` + `step` > `limit` and SATURATE=0: `count` ← low WIDTH bits of the sum, `wrap` ← 1, go to DONE.
  - "Greater than `limit`" includes a carry out of WIDTH bits. `wrap` is set on any overshoot past `limit`, whether or not the sum carries out of WIDTH bits.
- In RUN with `enable`=0: hold everything.
- With `step`=0 in RUN: `count` holds and the run never terminates. The only exits are `start` and reset.
- DONE lasts exactly one cycle, then the FSM returns to IDLE. `count` holds its final value through DONE and IDLE.
- In IDLE: `enable` is ignored and `count` holds.

## Timing
- Every output is registered; there are no combinational paths from inputs to outputs.
- A start at edge 0 makes `count` = `init` visible in the next cycle, with `busy`=1 (or `done`=1 if `init` equals the target).
- A terminal advance at edge k gives `done`=1 and `busy`=0 in cycle k+1, then IDLE in cycle k+2.
- Down run with stride 1 from `init`=N and `enable` held high: `busy` is high for N cycles and `done` pulses in the cycle after edge N.
- `start` in the DONE cycle: the run restarts at that edge, and `done` drops the following cycle.
- `start` mid-run: the count reloads with no DONE pulse for the abandoned run.
- Reset mid-run: IDLE and zeros at that edge, with no `done` pulse.

## Test plan
- Reset, then WIDTH=4, down, `init`=5, `step`=1, `enable` high → `count` 5,4,3,2,1,0 on consecutive cycles; `done` pulses once after edge 5; `busy` high for 5 cycles; `wrap`=0.
- Down, `init`=5, `step`=3, SATURATE=0 → `count` 5, then 2, then 15 with `wrap`=1 and `done`. Repeat with SATURATE=1 → `count` 5, 2, 0 with `wrap`=0.
- Up, `limit`=12, `init`=10, `step`=4, SATURATE=1 → `count` 10, then 12 with `done`. Repeat with SATURATE=0 → `count` 10, then 14 with `wrap`=1.
- Down, `init`=6, `step`=1, `enable` toggled 1,0,0,1 → `count` 6,5,5,5,4 (holds while `enable` is low); then `start` with `init`=2 → `count`=2, no `done` pulse.
- Down, `init`=0 → `done` in the next cycle and `busy` never high. Also `step`=0 for 20 cycles → `count` constant and `busy` stays high.
- Assert `rst_b` mid-run with `count`=3 → next cycle `count`=0, `busy`=0, `done`=0, `wrap`=0, and no later `done` pulse.

Source files
------------

// File: rtl/step_counter.sv
// Loadable up/down step counter with an IDLE/RUN/DONE sequencer; used as an iteration counter.
// Latency: every output is registered; count/busy/done update one cycle after start or advance.
// Backpressure: enable=0 stalls a run in place; start reloads from any state.
module step_counter #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [WIDTH-1:0] init,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] step,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] start_target;

    // One extra bit so an up-count carry out still compares as past the limit.
    assign diff         = {1'b0, count_q} - {1'b0, step};
    assign sum          = {1'b0, count_q} + {1'b0, step};
    assign start_target = dir ? limit : '0;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        dir_d   = dir_q;
        wrap_d  = wrap_q;
        if (start) begin
            count_d = init;
            dir_d   = dir;
            limit_d = limit;
            wrap_d  = 1'b0;
            state_d = (init == start_target) ? DONE : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (enable) begin
                        if (!dir_q) begin
                            if (step < count_q) begin
                                count_d = diff[WIDTH-1:0];
                            end else begin
                                state_d = DONE;
                                if (step == count_q || SATURATE) begin
                                    count_d = '0;
                                end else begin
                                    count_d = diff[WIDTH-1:0];
                                    wrap_d  = 1'b1;
                                end
                            end
                        end else begin
                            if (sum < {1'b0, limit_q}) begin
                                count_d = sum[WIDTH-1:0];
                            end else begin
                                state_d = DONE;
                                if (sum == {1'b0, limit_q} || SATURATE) begin
                                    count_d = limit_q;
                                end else begin
                                    count_d = sum[WIDTH-1:0];
                                    wrap_d  = 1'b1;
                                end
                            end
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '0;
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_step_counter.sv
// Bench for step_counter: wrapping and saturating instances share one stimulus stream,
// checked against an integer reference model plus directed expected values.
module tb_step_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_b = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] init = '0;
    logic         dir = 1'b0;
    logic [W-1:0] limit = '0;
    logic [W-1:0] step = '0;
    logic         enable = 1'b0;

    logic [W-1:0] count_w, count_s;
    logic         busy_w, busy_s, done_w, done_s, wrap_w, wrap_s;

    int checks = 0;
    int errors = 0;

    // Reference model state per instance: index 0 wraps, index 1 saturates.
    // phase: 0 idle, 1 running, 2 finished
    int m_cnt [2];
    int m_phase [2];
    int m_dir [2];
    int m_lim [2];
    int m_wrap [2];

    step_counter #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_b(rst_b), .start(start), .init(init), .dir(dir),
        .limit(limit), .step(step), .enable(enable),
        .count(count_w), .busy(busy_w), .done(done_w), .wrap(wrap_w)
    );

    step_counter #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_b(rst_b), .start(start), .init(init), .dir(dir),
        .limit(limit), .step(step), .enable(enable),
        .count(count_s), .busy(busy_s), .done(done_s), .wrap(wrap_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int sum, tgt;
        for (int s = 0; s < 2; s++) begin
            if (rst_b) begin
                m_phase[s] = 0; m_cnt[s] = 0; m_wrap[s] = 0; m_dir[s] = 0; m_lim[s] = 0;
            end else if (start) begin
                m_cnt[s]  = int'(init);
                m_dir[s]  = int'(dir);
                m_lim[s]  = int'(limit);
                m_wrap[s] = 0;
                tgt = dir ? int'(limit) : 0;
                m_phase[s] = (int'(init) == tgt) ? 2 : 1;
            end else if (m_phase[s] == 2) begin
                m_phase[s] = 0;
            end else if (m_phase[s] == 1 && enable) begin
                if (m_dir[s] == 0) begin
                    if (int'(step) < m_cnt[s]) begin
                        m_cnt[s] = m_cnt[s] - int'(step);
                    end else begin
                        m_phase[s] = 2;
                        if (int'(step) == m_cnt[s] || s == 1) m_cnt[s] = 0;
                        else begin
                            m_cnt[s]  = m_cnt[s] - int'(step) + MOD;
                            m_wrap[s] = 1;
                        end
                    end
                end else begin
                    sum = m_cnt[s] + int'(step);
                    if (sum < m_lim[s]) begin
                        m_cnt[s] = sum;
                    end else begin
                        m_phase[s] = 2;
                        if (sum == m_lim[s] || s == 1) m_cnt[s] = m_lim[s];
                        else begin
                            m_cnt[s]  = sum % MOD;
                            m_wrap[s] = 1;
                        end
                    end
                end
            end
        end
    endtask

    // One clock: model follows the inputs sampled at the edge, outputs checked 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        chk("w_count", 32'(count_w), 32'(m_cnt[0]));
        chk("w_busy",  32'(busy_w),  32'(m_phase[0] == 1));
        chk("w_done",  32'(done_w),  32'(m_phase[0] == 2));
        chk("w_wrap",  32'(wrap_w),  32'(m_wrap[0]));
        chk("s_count", 32'(count_s), 32'(m_cnt[1]));
        chk("s_busy",  32'(busy_s),  32'(m_phase[1] == 1));
        chk("s_done",  32'(done_s),  32'(m_phase[1] == 2));
        chk("s_wrap",  32'(wrap_s),  32'(m_wrap[1]));
    endtask

    task automatic go(input logic [W-1:0] i, input logic d, input logic [W-1:0] l,
                      input logic [W-1:0] st);
        start = 1'b1; init = i; dir = d; limit = l; step = st;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset
        rst_b = 1'b1;
        tick(); tick();
        chk("rst_count", 32'(count_w), 0);
        chk("rst_busy",  32'(busy_w), 0);
        chk("rst_done",  32'(done_s), 0);
        chk("rst_wrap",  32'(wrap_w), 0);
        rst_b = 1'b0;
        tick();

        // Down by 1 from 5
        enable = 1'b1;
        go(4'd5, 1'b0, 4'd0, 4'd1);
        chk("d1_c5", 32'(count_w), 5);
        chk("d1_busy", 32'(busy_w), 1);
        for (int k = 4; k >= 1; k--) begin
            tick();
            chk("d1_cnt", 32'(count_w), 32'(k));
            chk("d1_nodone", 32'(done_w), 0);
        end
        tick();
        chk("d1_c0", 32'(count_w), 0);
        chk("d1_done", 32'(done_w), 1);
        chk("d1_busy0", 32'(busy_w), 0);
        chk("d1_wrap", 32'(wrap_w), 0);
        tick();
        chk("d1_idle", 32'(done_w), 0);

        // Down by 3 from 5: wrap vs saturate
        go(4'd5, 1'b0, 4'd0, 4'd3);
        chk("d3_c5", 32'(count_s), 5);
        tick();
        chk("d3_c2", 32'(count_w), 2);
        tick();
        chk("d3_wcnt", 32'(count_w), 15);
        chk("d3_wwrap", 32'(wrap_w), 1);
        chk("d3_wdone", 32'(done_w), 1);
        chk("d3_scnt", 32'(count_s), 0);
        chk("d3_swrap", 32'(wrap_s), 0);
        chk("d3_sdone", 32'(done_s), 1);

        // Up to 12 from 10 by 4, started in the DONE cycle
        go(4'd10, 1'b1, 4'd12, 4'd4);
        chk("u_c10", 32'(count_w), 10);
        chk("u_rdone", 32'(done_w), 0);
        chk("u_wclr", 32'(wrap_w), 0);
        tick();
        chk("u_scnt", 32'(count_s), 12);
        chk("u_sdone", 32'(done_s), 1);
        chk("u_wcnt", 32'(count_w), 14);
        chk("u_wwrap", 32'(wrap_w), 1);
        tick();

        // Enable gating, then mid-run restart
        go(4'd6, 1'b0, 4'd0, 4'd1);
        chk("e_c6", 32'(count_w), 6);
        enable = 1'b1; tick(); chk("e_c5a", 32'(count_w), 5);
        enable = 1'b0; tick(); chk("e_c5b", 32'(count_w), 5);
        tick(); chk("e_c5c", 32'(count_w), 5);
        enable = 1'b1; tick(); chk("e_c4", 32'(count_w), 4);
        go(4'd2, 1'b0, 4'd0, 4'd1);
        chk("e_re2", 32'(count_w), 2);
        chk("e_nodone", 32'(done_w), 0);
        tick(); tick();
        chk("e_done", 32'(done_s), 1);
        tick();

        // Start at target, then stride 0 hold
        go(4'd0, 1'b0, 4'd7, 4'd1);
        chk("z_done", 32'(done_w), 1);
        chk("z_busy", 32'(busy_w), 0);
        tick();
        chk("z_busy2", 32'(busy_w), 0);
        go(4'd9, 1'b0, 4'd0, 4'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("s0_cnt", 32'(count_w), 9);
            chk("s0_busy", 32'(busy_s), 1);
        end

        // Reset mid-run
        go(4'd5, 1'b0, 4'd0, 4'd1);
        tick(); tick();
        chk("r_c3", 32'(count_w), 3);
        rst_b = 1'b1;
        tick();
        chk("r_cnt", 32'(count_w), 0);
        chk("r_busy", 32'(busy_w), 0);
        chk("r_done", 32'(done_w), 0);
        chk("r_wrap", 32'(wrap_w), 0);
        rst_b = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("r_nodone", 32'(done_w), 0);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            rst_b  = ($urandom_range(0, 99) == 0);
            start  = ($urandom_range(0, 9) == 0);
            init   = W'($urandom);
            dir    = 1'($urandom);
            limit  = W'($urandom);
            step   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 5));
            enable = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
